// File: rtl/axi4_lite_master_if_pkg.sv
// Shared definitions for the AXI4-lite initiator used by the tetris game
// logic: FSM state encoding and fixed AXI field values.
package axi4_lite_master_if_pkg;

  // Transaction FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [3:0] WSTRB_ALL     = 4'hF;
  localparam logic [2:0] AXI_PROT_NONE = 3'b000;

endpackage

// File: rtl/axi4_lite_master_if.sv
// AXI4-lite initiator: turns a single-beat command/response handshake into
// one AXI4-lite write (AW/W/B) or read (AR/R) transaction at a time.
//
// Ports:
//   i_pixclk, i_reset        clock, synchronous active-high reset
//   i_cmd_* / o_cmd_ready    command in (we, word index, write data)
//   o_rsp_* / i_rsp_ready    response out (read data, error flag)
//   o_busy                   high whenever a transaction is in progress
//   m00_axi_*                AXI4-lite master port (all outputs registered)
module axi4_lite_master_if
  import axi4_lite_master_if_pkg::*;
#(
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int C_M00_AXI_ADDR_WIDTH = 32,
  parameter int CMD_AWIDTH           = 4,
  parameter logic [C_M00_AXI_ADDR_WIDTH-1:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic                              i_pixclk,
  input  logic                              i_reset,
  input  logic                              i_cmd_valid,
  output logic                              o_cmd_ready,
  input  logic                              i_cmd_we,
  input  logic [CMD_AWIDTH-1:0]             i_cmd_addr,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   i_cmd_wdata,
  output logic                              o_rsp_valid,
  input  logic                              i_rsp_ready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic                              o_rsp_err,
  output logic                              o_busy,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic [2:0]                        m00_axi_awprot,
  output logic                              m00_axi_awvalid,
  input  logic                              m00_axi_awready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [3:0]                        m00_axi_wstrb,
  output logic                              m00_axi_wvalid,
  input  logic                              m00_axi_wready,
  input  logic [1:0]                        m00_axi_bresp,
  input  logic                              m00_axi_bvalid,
  output logic                              m00_axi_bready,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
  output logic [2:0]                        m00_axi_arprot,
  output logic                              m00_axi_arvalid,
  input  logic                              m00_axi_arready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
  input  logic [1:0]                        m00_axi_rresp,
  input  logic                              m00_axi_rvalid,
  output logic                              m00_axi_rready
);

  state_t state_r, state_s;

  logic                            cmd_ready_r, cmd_ready_s;
  logic                            busy_r, busy_s;
  logic [C_M00_AXI_ADDR_WIDTH-1:0] awaddr_r, awaddr_s;
  logic                            awvalid_r, awvalid_s;
  logic [C_M00_AXI_DATA_WIDTH-1:0] wdata_r, wdata_s;
  logic [3:0]                      wstrb_r;
  logic                            wvalid_r, wvalid_s;
  logic                            bready_r, bready_s;
  logic [C_M00_AXI_ADDR_WIDTH-1:0] araddr_r, araddr_s;
  logic                            arvalid_r, arvalid_s;
  logic                            rready_r, rready_s;
  logic                            rsp_valid_r, rsp_valid_s;
  logic [C_M00_AXI_DATA_WIDTH-1:0] rsp_rdata_r, rsp_rdata_s;
  logic                            rsp_err_r, rsp_err_s;
  logic                            aw_done_r, aw_done_s;
  logic                            w_done_r, w_done_s;

  // Word index scaled to a byte offset within the target region.
  logic [C_M00_AXI_ADDR_WIDTH-1:0] byte_addr_s;
  assign byte_addr_s = BASE_ADDR +
    {{(C_M00_AXI_ADDR_WIDTH-CMD_AWIDTH-2){1'b0}}, i_cmd_addr, 2'b00};

  // Next-state and next-output computation; every output register is loaded
  // from here so no valid ever follows a ready input combinationally.
  always_comb begin
    state_s     = state_r;
    awaddr_s    = awaddr_r;
    awvalid_s   = awvalid_r;
    wdata_s     = wdata_r;
    wvalid_s    = wvalid_r;
    araddr_s    = araddr_r;
    arvalid_s   = arvalid_r;
    rsp_rdata_s = rsp_rdata_r;
    rsp_err_s   = rsp_err_r;
    aw_done_s   = aw_done_r;
    w_done_s    = w_done_r;

    case (state_r)
      ST_IDLE: begin
        if (i_cmd_valid && cmd_ready_r) begin
          aw_done_s = 1'b0;
          w_done_s  = 1'b0;
          if (i_cmd_we) begin
            state_s   = ST_WR_REQ;
            awaddr_s  = byte_addr_s;
            wdata_s   = i_cmd_wdata;
            awvalid_s = 1'b1;
            wvalid_s  = 1'b1;
          end else begin
            state_s   = ST_RD_REQ;
            araddr_s  = byte_addr_s;
            arvalid_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_WR_REQ: begin
        // AW and W complete independently; each valid drops after its own
        // handshake and a done flag remembers it.
        if (awvalid_r && m00_axi_awready) begin
          awvalid_s = 1'b0;
          aw_done_s = 1'b1;
        end else begin
          awvalid_s = awvalid_r;
          aw_done_s = aw_done_r;
        end
        if (wvalid_r && m00_axi_wready) begin
          wvalid_s = 1'b0;
          w_done_s = 1'b1;
        end else begin
          wvalid_s = wvalid_r;
          w_done_s = w_done_r;
        end
        if (aw_done_s && w_done_s) begin
          state_s = ST_WR_RESP;
        end else begin
          state_s = ST_WR_REQ;
        end
      end

      ST_WR_RESP: begin
        if (m00_axi_bvalid && bready_r) begin
          rsp_err_s   = (m00_axi_bresp != AXI_RESP_OKAY);
          rsp_rdata_s = '0;
          state_s     = ST_RSP;
        end else begin
          state_s = ST_WR_RESP;
        end
      end

      ST_RD_REQ: begin
        if (arvalid_r && m00_axi_arready) begin
          arvalid_s = 1'b0;
          state_s   = ST_RD_DATA;
        end else begin
          state_s = ST_RD_REQ;
        end
      end

      ST_RD_DATA: begin
        if (m00_axi_rvalid && rready_r) begin
          rsp_rdata_s = m00_axi_rdata;
          rsp_err_s   = (m00_axi_rresp != AXI_RESP_OKAY);
          state_s     = ST_RSP;
        end else begin
          state_s = ST_RD_DATA;
        end
      end

      ST_RSP: begin
        if (i_rsp_ready && rsp_valid_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RSP;
        end
      end

      default: begin
        state_s   = ST_IDLE;
        awvalid_s = 1'b0;
        wvalid_s  = 1'b0;
        arvalid_s = 1'b0;
      end
    endcase

    // State-qualified strobes are derived from the next state so they are
    // registered alongside it and line up with the state they belong to.
    cmd_ready_s = (state_s == ST_IDLE);
    busy_s      = (state_s != ST_IDLE);
    bready_s    = (state_s == ST_WR_RESP);
    rready_s    = (state_s == ST_RD_DATA);
    rsp_valid_s = (state_s == ST_RSP);
  end

  // State register and every registered output; reset clears all of them.
  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      awaddr_r    <= '0;
      awvalid_r   <= 1'b0;
      wdata_r     <= '0;
      wstrb_r     <= 4'h0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      araddr_r    <= '0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      cmd_ready_r <= cmd_ready_s;
      busy_r      <= busy_s;
      awaddr_r    <= awaddr_s;
      awvalid_r   <= awvalid_s;
      wdata_r     <= wdata_s;
      wstrb_r     <= WSTRB_ALL;
      wvalid_r    <= wvalid_s;
      bready_r    <= bready_s;
      araddr_r    <= araddr_s;
      arvalid_r   <= arvalid_s;
      rready_r    <= rready_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_rdata_r <= rsp_rdata_s;
      rsp_err_r   <= rsp_err_s;
      aw_done_r   <= aw_done_s;
      w_done_r    <= w_done_s;
    end
  end

  assign o_cmd_ready     = cmd_ready_r;
  assign o_busy          = busy_r;
  assign o_rsp_valid     = rsp_valid_r;
  assign o_rsp_rdata     = rsp_rdata_r;
  assign o_rsp_err       = rsp_err_r;
  assign m00_axi_awaddr  = awaddr_r;
  assign m00_axi_awprot  = AXI_PROT_NONE;
  assign m00_axi_awvalid = awvalid_r;
  assign m00_axi_wdata   = wdata_r;
  assign m00_axi_wstrb   = wstrb_r;
  assign m00_axi_wvalid  = wvalid_r;
  assign m00_axi_bready  = bready_r;
  assign m00_axi_araddr  = araddr_r;
  assign m00_axi_arprot  = AXI_PROT_NONE;
  assign m00_axi_arvalid = arvalid_r;
  assign m00_axi_rready  = rready_r;

endmodule

// File: tb/tb_axi4_lite_master_if.sv
// Self-checking bench for axi4_lite_master_if: a directed vector table, a
// back-to-back write stream, a mid-transaction reset and randomized
// transactions, all checked against a latency/address model of the block.
module tb_axi4_lite_master_if;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axi4_lite_master_if dut (
    .i_pixclk(clk), .i_reset(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_we(cmd_we),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err), .o_busy(busy),
    .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot),
    .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
    .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
    .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
    .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
    .m00_axi_araddr(araddr), .m00_axi_arprot(arprot),
    .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
    .m00_axi_rdata(rdata), .m00_axi_rresp(rresp),
    .m00_axi_rvalid(rvalid), .m00_axi_rready(rready)
  );

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    int          aw_d, w_d, b_d;
    logic [1:0]  bresp;
    int          ar_d, r_d;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          rsp_d;
    bit          junk;
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                              input int aw_d, input int w_d, input int b_d, input logic [1:0] br,
                              input int ar_d, input int r_d, input logic [31:0] rd,
                              input logic [1:0] rr, input int rsp_d, input bit junk,
                              input logic [31:0] ea, input logic [31:0] erd,
                              input logic ee, input int el);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wd;
    v.aw_d = aw_d; v.w_d = w_d; v.b_d = b_d; v.bresp = br;
    v.ar_d = ar_d; v.r_d = r_d; v.rdata = rd; v.rresp = rr;
    v.rsp_d = rsp_d; v.junk = junk;
    v.exp_addr = ea; v.exp_rdata = erd; v.exp_err = ee; v.exp_lat = el;
    return v;
  endfunction

  // Reference model: byte address, response and accept-to-response latency
  // from the transaction rules (AW/W overlap, then B; or AR then R).
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_addr = BASE + 32'(v.addr) * 32'd4;
    if (v.we) begin
      r.exp_rdata = 32'h0;
      r.exp_err   = (v.bresp != 2'b00);
      r.exp_lat   = 3 + ((v.aw_d > v.w_d) ? v.aw_d : v.w_d) + v.b_d;
    end else begin
      r.exp_rdata = v.rdata;
      r.exp_err   = (v.rresp != 2'b00);
      r.exp_lat   = 3 + v.ar_d + v.r_d;
    end
    return r;
  endfunction

  task automatic slave_idle();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    rsp_ready = 1'b0;
  endtask

  // One full transaction: command, cycle-by-cycle slave with given delays,
  // response with given backpressure. Called and returns at a negedge.
  task automatic run_txn(input vec_t v, input string tag);
    int guard, cyc;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, rsp_cnt, aw_hs, w_hs, ar_hs;
    bit b_hs, r_hs, rsp_hs, done;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; rsp_cnt = 0;
    aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0; rsp_hs = 0; done = 0;
    slave_idle();
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk1({tag, " cmd_ready idle"}, cmd_ready, 1'b1);
    chk1({tag, " busy idle"}, busy, 1'b0);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.addr; cmd_wdata = v.wdata;
    @(posedge clk);
    @(negedge clk);
    if (v.junk) begin
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 4'hF; cmd_wdata = 32'h0;
    end else begin
      cmd_valid = 1'b0;
    end
    cyc = 1;
    while (!done && cyc < 300) begin
      chk1({tag, " busy"}, busy, 1'b1);
      chk1({tag, " cmd_ready busy"}, cmd_ready, 1'b0);
      if (awvalid) begin
        aw_cnt++;
        chk({tag, " awaddr"}, awaddr, v.exp_addr);
        chk({tag, " awprot"}, 32'(awprot), 32'h0);
        awready = (aw_cnt > v.aw_d);
        if (awready) aw_hs++;
      end else begin
        awready = 1'b0;
      end
      if (wvalid) begin
        w_cnt++;
        chk({tag, " wdata"}, wdata, v.wdata);
        chk({tag, " wstrb"}, 32'(wstrb), 32'hF);
        wready = (w_cnt > v.w_d);
        if (wready) w_hs++;
      end else begin
        wready = 1'b0;
      end
      if (bready) begin
        chki({tag, " bready after aw"}, aw_hs, 1);
        chki({tag, " bready after w"}, w_hs, 1);
        if (!b_hs) begin
          b_cnt++;
          bvalid = (b_cnt > v.b_d);
          bresp  = bvalid ? v.bresp : 2'b00;
          if (bvalid) b_hs = 1;
        end else begin
          b_cnt++;
          bvalid = 1'b0;
        end
      end else begin
        bvalid = 1'b0;
      end
      if (arvalid) begin
        ar_cnt++;
        chk({tag, " araddr"}, araddr, v.exp_addr);
        chk({tag, " arprot"}, 32'(arprot), 32'h0);
        arready = (ar_cnt > v.ar_d);
        if (arready) ar_hs++;
      end else begin
        arready = 1'b0;
      end
      if (rready) begin
        r_cnt++;
        if (!r_hs) begin
          rvalid = (r_cnt > v.r_d);
          rdata  = rvalid ? v.rdata : 32'h0BAD_0000;
          rresp  = rvalid ? v.rresp : 2'b00;
          if (rvalid) r_hs = 1;
        end else begin
          rvalid = 1'b0;
        end
      end else begin
        rvalid = 1'b0;
      end
      if (rsp_valid) begin
        if (rsp_cnt == 0) chki({tag, " latency"}, cyc, v.exp_lat);
        rsp_cnt++;
        chk({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
        chk1({tag, " rsp_err"}, rsp_err, v.exp_err);
        rsp_ready = (rsp_cnt > v.rsp_d);
        if (rsp_ready) rsp_hs = 1;
      end else begin
        rsp_ready = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (rsp_hs) done = 1;
    end
    cmd_valid = 1'b0;
    slave_idle();
    chk1({tag, " completed"}, done, 1'b1);
    chk1({tag, " busy after"}, busy, 1'b0);
    chk1({tag, " cmd_ready after"}, cmd_ready, 1'b1);
    chk1({tag, " rsp_valid after"}, rsp_valid, 1'b0);
    chki({tag, " awvalid cycles"}, aw_cnt, v.we ? v.aw_d + 1 : 0);
    chki({tag, " wvalid cycles"}, w_cnt, v.we ? v.w_d + 1 : 0);
    chki({tag, " bready cycles"}, b_cnt, v.we ? v.b_d + 1 : 0);
    chki({tag, " arvalid cycles"}, ar_cnt, v.we ? 0 : v.ar_d + 1);
    chki({tag, " rready cycles"}, r_cnt, v.we ? 0 : v.r_d + 1);
    chki({tag, " rsp_valid cycles"}, rsp_cnt, v.rsp_d + 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, " cmd_ready"}, cmd_ready, 1'b0);
    chk1({tag, " busy"}, busy, 1'b0);
    chk1({tag, " rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, " rsp_rdata"}, rsp_rdata, 32'h0);
    chk1({tag, " rsp_err"}, rsp_err, 1'b0);
    chk({tag, " awaddr"}, awaddr, 32'h0);
    chk({tag, " wdata"}, wdata, 32'h0);
    chk({tag, " araddr"}, araddr, 32'h0);
    chk({tag, " valids"}, {27'h0, awvalid, wvalid, arvalid, bready, rready}, 32'h0);
  endtask

  vec_t tbl[6];
  vec_t v;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 4'h0; cmd_wdata = 32'h0;
    slave_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    tbl[0] = mk(1'b1, 4'd3,  32'hDEAD_BEEF, 0, 0, 0, 2'b00, 0, 0, 32'h0, 2'b00, 0, 1'b0,
                32'h4000_000C, 32'h0, 1'b0, 3);
    tbl[1] = mk(1'b0, 4'd5,  32'h0, 0, 0, 0, 2'b00, 0, 4, 32'h1234_5678, 2'b00, 0, 1'b0,
                32'h4000_0014, 32'h1234_5678, 1'b0, 7);
    tbl[2] = mk(1'b1, 4'd7,  32'hA5A5_0001, 3, 0, 0, 2'b00, 0, 0, 32'h0, 2'b00, 0, 1'b0,
                32'h4000_001C, 32'h0, 1'b0, 6);
    tbl[3] = mk(1'b1, 4'd1,  32'h0000_0042, 0, 0, 0, 2'b10, 0, 0, 32'h0, 2'b00, 5, 1'b0,
                32'h4000_0004, 32'h0, 1'b1, 3);
    tbl[4] = mk(1'b0, 4'd15, 32'h0, 0, 0, 0, 2'b00, 2, 1, 32'hCAFE_F00D, 2'b11, 1, 1'b1,
                32'h4000_003C, 32'hCAFE_F00D, 1'b1, 6);
    tbl[5] = mk(1'b1, 4'd0,  32'h1111_2222, 0, 2, 2, 2'b00, 0, 0, 32'h0, 2'b00, 0, 1'b0,
                32'h4000_0000, 32'h0, 1'b0, 7);
    for (int i = 0; i < 6; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // Grid-line stream: back-to-back writes with the producer holding a
    // further command on the bus while each one is in flight.
    for (int a = 0; a < 10; a++) begin
      v = mk(1'b1, 4'(a), 32'hC0DE_0000 + 32'(a), 0, 0, 0, 2'b00, 0, 0, 32'h0, 2'b00, 0,
             1'b1, 32'h0, 32'h0, 1'b0, 0);
      run_txn(model(v), $sformatf("b2b%0d", a));
    end

    // Reset while the write address channel is stalled.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'd2; cmd_wdata = 32'h5555_AAAA;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk1("rst_mid awvalid", awvalid, 1'b1);
    chk1("rst_mid wvalid", wvalid, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst_mid");
    rst = 1'b0;
    v = mk(1'b0, 4'd9, 32'h0, 0, 0, 0, 2'b00, 1, 0, 32'h0F0F_1234, 2'b00, 0, 1'b0,
           32'h0, 32'h0, 1'b0, 0);
    run_txn(model(v), "post_rst");

    for (int i = 0; i < 40; i++) begin
      v.we    = 1'($urandom_range(0, 1));
      v.addr  = 4'($urandom_range(0, 15));
      v.wdata = $urandom;
      v.aw_d  = $urandom_range(0, 3);
      v.w_d   = $urandom_range(0, 3);
      v.b_d   = $urandom_range(0, 3);
      v.bresp = 2'($urandom_range(0, 3));
      v.ar_d  = $urandom_range(0, 3);
      v.r_d   = $urandom_range(0, 3);
      v.rdata = $urandom;
      v.rresp = 2'($urandom_range(0, 3));
      v.rsp_d = $urandom_range(0, 3);
      v.junk  = 1'($urandom_range(0, 1));
      run_txn(model(v), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
